port_ecc_wr_arbiter: RTL and testbench
======================================

Name: port_ecc_wr_arbiter

Overview:
Shares the single write port of the ECC code SRAM among the per-port write-ECC encoders. Each port's encoder emits one 8-bit ECC code per 8-word (16-bit) batch, tagged with the target SRAM address. The block buffers these codes in small per-port FIFOs and drains them round-robin into the ECC SRAM, one write per cycle. It applies SRAM stall backpressure and reports overflow per port.

Parameters:
PORT_NUM, 4, number of requesting ports (2..16)
ADDR_W, 11, ECC SRAM address width
FIFO_DEPTH, 4, entries per port FIFO (power of 2, >=2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req_vld  input  PORT_NUM  per-port ECC code valid
req_addr  input  PORT_NUM*ADDR_W  per-port target address; port i at bits [i*ADDR_W +: ADDR_W]
req_code  input  PORT_NUM*8  per-port ECC code; port i at bits [i*8 +: 8]
req_rdy  output  PORT_NUM  per-port FIFO not full
ecc_wr_stall  input  1  SRAM busy; no write may be issued this cycle
ecc_wr_en  output  1  SRAM write strobe (registered)
ecc_wr_addr  output  ADDR_W  SRAM write address (registered)
ecc_wr_data  output  8  SRAM write data (registered)
ecc_wr_port  output  log2(PORT_NUM)  source port of the current write (debug)
ovf_err  output  PORT_NUM  sticky overflow flag per port
err_clr  input  1  clears all ovf_err bits

Behaviour:
- Reset (async, rst_n=0): FIFOs emptied; ecc_wr_en/addr/data/port=0; ovf_err=0; last-grant pointer=PORT_NUM-1, so port 0 has top priority after reset. req_rdy follows FIFO state, so it is all-ones during reset.
- Push: on a clk edge where req_vld[i]&&req_rdy[i], the {addr,code} pair is written to FIFO i.
- req_rdy[i] = (count_i != FIFO_DEPTH). It depends only on the registered count. A full FIFO refuses a push even in a cycle where it is popped.
- Overflow: req_vld[i]&&!req_rdy[i] sets ovf_err[i] at the edge. The code is dropped.
- err_clr clears all ovf_err bits. Same-cycle overflow and err_clr: set wins.
- Arbitration is combinational on FIFO non-empty flags. Search order: last_grant+1, +2, ... (mod PORT_NUM). The first non-empty FIFO wins.
- Grant and pop occur only when ecc_wr_stall=0 and at least one FIFO is non-empty. On a grant edge: pop the head entry, last_grant<=winner, ecc_wr_en<=1, and load addr/data/port from the popped entry.
- No grant (stall, or all FIFOs empty): ecc_wr_en<=0, last_grant unchanged, addr/data/port hold previous values.
- Latency: an entry pushed at edge T can be written no earlier than the cycle after edge T+1 (2 cycles from req_vld to ecc_wr_en). No bypass path.
- Simultaneous push and pop on a non-full FIFO: count unchanged, both take effect.
- Pointer wrap: FIFO read/write pointers are log2(FIFO_DEPTH)+1 bits. count = wr_ptr - rd_ptr, with natural wrap.
- Throughput: with no stall, one SRAM write per cycle sustained. Every port with a non-empty FIFO is granted within PORT_NUM cycles.
- ecc_wr_stall is sampled only for the grant decision. It never blocks pushes.

Test Plan:
- Reset then single request: port 2 pushes addr=0x05A, code=0xC3 → ecc_wr_en high exactly 2 cycles later, with addr=0x05A, data=0xC3, port=2, for one cycle only.
- All 4 ports push one entry each in the same cycle → writes appear on consecutive cycles in port order 0,1,2,3; ecc_wr_en then drops.
- Fairness: ports 0 and 3 keep FIFOs non-empty continuously → grants alternate 0,3,0,3. No port waits more than PORT_NUM cycles.
- Stall: 3 entries queued, ecc_wr_stall held high for 5 cycles → ecc_wr_en=0 during the stall and the pointer is unchanged. After release, the 3 writes issue back-to-back in the original round-robin order.
- Overflow: stall held while port 1 pushes 5 codes → req_rdy[1]=0 after the 4th push, ovf_err[1]=1 after the 5th. After release, exactly 4 writes are issued. err_clr clears the flag.
- Async reset mid-drain: rst_n low with 3 entries queued → outputs go to 0 immediately. After release there are no writes, and the next request goes to port 0 first.

Source files
------------

// File: rtl/port_ecc_wr_arbiter.sv
// Round-robin write arbiter for the shared ECC code SRAM port.
// Per-port FIFOs buffer {addr, code} pairs; one FIFO head is drained per unstalled cycle.
module port_ecc_wr_arbiter #(
    parameter int PORT_NUM   = 4,
    parameter int ADDR_W     = 11,
    parameter int FIFO_DEPTH = 4,
    localparam int PW        = $clog2(PORT_NUM)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PORT_NUM-1:0]        req_vld,
    input  logic [PORT_NUM*ADDR_W-1:0] req_addr,
    input  logic [PORT_NUM*8-1:0]      req_code,
    output logic [PORT_NUM-1:0]        req_rdy,
    input  logic                       ecc_wr_stall,
    output logic                       ecc_wr_en,
    output logic [ADDR_W-1:0]          ecc_wr_addr,
    output logic [7:0]                 ecc_wr_data,
    output logic [PW-1:0]              ecc_wr_port,
    output logic [PORT_NUM-1:0]        ovf_err,
    input  logic                       err_clr
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int ENT_W = ADDR_W + 8;

    typedef logic [PTR_W-1:0] ptr_t;

    logic [ENT_W-1:0] mem_q [PORT_NUM][FIFO_DEPTH];

    ptr_t wr_ptr_q [PORT_NUM];
    ptr_t wr_ptr_d [PORT_NUM];
    ptr_t rd_ptr_q [PORT_NUM];
    ptr_t rd_ptr_d [PORT_NUM];
    ptr_t count    [PORT_NUM];

    logic [PORT_NUM-1:0] not_empty;
    logic [PORT_NUM-1:0] push;
    logic [PORT_NUM-1:0] pop;
    logic [PORT_NUM-1:0] ovf_set;

    logic [PW-1:0]    last_q, last_d;
    logic [PW-1:0]    winner;
    logic [PW-1:0]    cand;
    logic             found;
    logic             grant;
    logic [ENT_W-1:0] head;

    logic              en_q, en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [PW-1:0]     port_q, port_d;
    logic [PORT_NUM-1:0] ovf_q, ovf_d;

    // Pointers carry one extra wrap bit so full and empty differ without a separate flag.
    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            count[i]     = wr_ptr_q[i] - rd_ptr_q[i];
            req_rdy[i]   = (count[i] != ptr_t'(FIFO_DEPTH));
            not_empty[i] = (count[i] != '0);
        end
    end

    assign push    = req_vld & req_rdy;
    assign ovf_set = req_vld & ~req_rdy;

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        winner = last_q;
        cand   = last_q;
        found  = 1'b0;
        for (int off = 1; off <= PORT_NUM; off++) begin
            cand = PW'((int'(last_q) + off) % PORT_NUM);
            if (!found && not_empty[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign grant = !ecc_wr_stall && (|not_empty);
    assign head  = mem_q[winner][rd_ptr_q[winner][AW-1:0]];

    always_comb begin
        pop = '0;
        if (grant) begin
            pop[winner] = 1'b1;
        end
        for (int i = 0; i < PORT_NUM; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            if (push[i]) begin
                wr_ptr_d[i] = wr_ptr_q[i] + ptr_t'(1);
            end
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + ptr_t'(1);
            end
        end
    end

    always_comb begin
        en_d   = grant;
        last_d = last_q;
        addr_d = addr_q;
        data_d = data_q;
        port_d = port_q;
        if (grant) begin
            last_d = winner;
            addr_d = head[ENT_W-1 -: ADDR_W];
            data_d = head[7:0];
            port_d = winner;
        end
        // A new overflow in the same cycle as err_clr must survive the clear.
        ovf_d = (err_clr ? '0 : ovf_q) | ovf_set;
    end

    // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PORT_NUM; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i][AW-1:0]] <= {req_addr[i*ADDR_W +: ADDR_W], req_code[i*8 +: 8]};
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
            last_q <= PW'(PORT_NUM - 1);
            en_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            port_q <= '0;
            ovf_q  <= '0;
        end else begin
            for (int i = 0; i < PORT_NUM; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
            end
            last_q <= last_d;
            en_q   <= en_d;
            addr_q <= addr_d;
            data_q <= data_d;
            port_q <= port_d;
            ovf_q  <= ovf_d;
        end
    end

    assign ecc_wr_en   = en_q;
    assign ecc_wr_addr = addr_q;
    assign ecc_wr_data = data_q;
    assign ecc_wr_port = port_q;
    assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_port_ecc_wr_arbiter.sv
// Scoreboard bench for port_ecc_wr_arbiter: a queue-based reference model predicts every SRAM
// write, handshake and overflow flag; a negedge monitor compares the DUT against it.
module tb_port_ecc_wr_arbiter;

    localparam int P  = 4;
    localparam int AW = 11;
    localparam int D  = 4;
    localparam int PW = $clog2(P);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [P-1:0]      req_vld;
    logic [P*AW-1:0]   req_addr;
    logic [P*8-1:0]    req_code;
    logic [P-1:0]      req_rdy;
    logic              ecc_wr_stall;
    logic              ecc_wr_en;
    logic [AW-1:0]     ecc_wr_addr;
    logic [7:0]        ecc_wr_data;
    logic [PW-1:0]     ecc_wr_port;
    logic [P-1:0]      ovf_err;
    logic              err_clr;

    port_ecc_wr_arbiter #(.PORT_NUM(P), .ADDR_W(AW), .FIFO_DEPTH(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_vld      (req_vld),
        .req_addr     (req_addr),
        .req_code     (req_code),
        .req_rdy      (req_rdy),
        .ecc_wr_stall (ecc_wr_stall),
        .ecc_wr_en    (ecc_wr_en),
        .ecc_wr_addr  (ecc_wr_addr),
        .ecc_wr_data  (ecc_wr_data),
        .ecc_wr_port  (ecc_wr_port),
        .ovf_err      (ovf_err),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    code;
    } ent_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic [PW-1:0] port;
    } wr_t;

    // Reference model: circular buffers per port, a rotating priority index, expected-write queue.
    ent_t         mq [P][D];
    int           mh [P];
    int           mc [P];
    int           m_last;
    logic         m_en;
    logic [P-1:0] m_ovf;
    wr_t          exp_q [$];

    logic [P-1:0] s_rdy;
    int           s_idx;
    wr_t          s_w;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [P-1:0] model_rdy();
        logic [P-1:0] r;
        for (int i = 0; i < P; i++) r[i] = (mc[i] != D);
        return r;
    endfunction

    function automatic bit model_busy();
        bit b = (exp_q.size() != 0);
        for (int i = 0; i < P; i++) if (mc[i] != 0) b = 1'b1;
        return b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < P; i++) begin
                mh[i] = 0;
                mc[i] = 0;
            end
            m_last = P - 1;
            m_en   = 1'b0;
            m_ovf  = '0;
            exp_q.delete();
        end else begin
            s_rdy = model_rdy();
            m_en  = 1'b0;
            if (!ecc_wr_stall) begin
                for (int off = 1; off <= P; off++) begin
                    s_idx = (m_last + off) % P;
                    if (!m_en && mc[s_idx] > 0) begin
                        s_w.addr = mq[s_idx][mh[s_idx]].addr;
                        s_w.data = mq[s_idx][mh[s_idx]].code;
                        s_w.port = PW'(s_idx);
                        exp_q.push_back(s_w);
                        mh[s_idx] = (mh[s_idx] + 1) % D;
                        mc[s_idx] = mc[s_idx] - 1;
                        m_last    = s_idx;
                        m_en      = 1'b1;
                    end
                end
            end
            if (err_clr) m_ovf = '0;
            for (int i = 0; i < P; i++) begin
                if (req_vld[i]) begin
                    if (s_rdy[i]) begin
                        mq[i][(mh[i] + mc[i]) % D] = {req_addr[i*AW +: AW], req_code[i*8 +: 8]};
                        mc[i] = mc[i] + 1;
                    end else begin
                        m_ovf[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: pops an expected write whenever the DUT strobes the SRAM.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("wr_en", ecc_wr_en, m_en);
            if (ecc_wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL wr_unexpected: actual write addr=%0h data=%0h, required none (t=%0t)",
                             ecc_wr_addr, ecc_wr_data, $time);
                end else begin
                    s_w = exp_q.pop_front();
                    check("wr_addr", ecc_wr_addr, s_w.addr);
                    check("wr_data", ecc_wr_data, s_w.data);
                    check("wr_port", ecc_wr_port, s_w.port);
                end
            end
            check("req_rdy", req_rdy, model_rdy());
            check("ovf_err", ovf_err, m_ovf);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        req_vld = '0;
        err_clr = 1'b0;
    endtask

    task automatic push1(input int p, input logic [AW-1:0] a, input logic [7:0] c);
        req_vld[p]          = 1'b1;
        req_addr[p*AW +: AW] = a;
        req_code[p*8 +: 8]   = c;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        req_vld      = '0;
        req_addr     = '0;
        req_code     = '0;
        ecc_wr_stall = 1'b0;
        err_clr      = 1'b0;
        rst_n        = 1'b1;
        #1 rst_n     = 1'b0;
        #1;
        check("rst_en",   ecc_wr_en,   0);
        check("rst_addr", ecc_wr_addr, 0);
        check("rst_data", ecc_wr_data, 0);
        check("rst_port", ecc_wr_port, 0);
        check("rst_ovf",  ovf_err,     0);
        check("rst_rdy",  req_rdy,     {P{1'b1}});
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Single request: write expected two cycles after the push.
        push1(2, 11'h05A, 8'hC3);
        tick();
        idle(5);

        // All ports at once: drained in port order 0..3.
        for (int p = 0; p < P; p++) push1(p, AW'($urandom), 8'($urandom));
        tick();
        idle(6);

        // Fairness: ports 0 and 3 kept busy.
        for (int k = 0; k < 24; k++) begin
            if (mc[0] < D) push1(0, AW'($urandom), 8'($urandom));
            if (mc[3] < D) push1(3, AW'($urandom), 8'($urandom));
            tick();
        end
        idle(10);

        // Stall with three entries queued.
        ecc_wr_stall = 1'b1;
        for (int p = 1; p < P; p++) push1(p, AW'($urandom), 8'($urandom));
        tick();
        idle(4);
        ecc_wr_stall = 1'b0;
        idle(6);

        // Overflow on port 1 while stalled, then clear.
        ecc_wr_stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            push1(1, AW'(k + 16), 8'($urandom));
            tick();
        end
        check("ovf_port1_set", ovf_err[1], 1);
        check("rdy_port1_full", req_rdy[1], 0);
        ecc_wr_stall = 1'b0;
        idle(7);
        err_clr = 1'b1;
        tick();
        idle(2);

        // Randomized traffic with stalls, overflows and clears.
        for (int k = 0; k < 600; k++) begin
            for (int p = 0; p < P; p++)
                if ($urandom % 3 == 0) push1(p, AW'($urandom), 8'($urandom));
            ecc_wr_stall = ($urandom % 4 == 0);
            err_clr      = ($urandom % 20 == 0);
            tick();
        end
        ecc_wr_stall = 1'b0;
        idle(20);

        // Async reset in the middle of a drain.
        ecc_wr_stall = 1'b1;
        for (int p = 1; p < P; p++) push1(p, AW'($urandom), 8'($urandom));
        tick();
        tick();
        ecc_wr_stall = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_en",   ecc_wr_en,   0);
        check("midrst_addr", ecc_wr_addr, 0);
        check("midrst_data", ecc_wr_data, 0);
        check("midrst_port", ecc_wr_port, 0);
        check("midrst_rdy",  req_rdy,     {P{1'b1}});
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(4);
        push1(3, 11'h3A5, 8'h5A);
        push1(0, 11'h111, 8'hA5);
        tick();
        idle(6);

        for (int k = 0; k < 60 && model_busy(); k++) tick();
        check("drain_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
